// File: rtl/ntt_bf4_core.sv
// rtl/ntt_bf4_core.sv - radix-2x2 modular butterfly core (CT for NTT, GS for INTT), mod 8380417
// Seven-stage pipeline: input, pre-add, multiply, reduce, post/pre-add, multiply, reduce/post-add.
module ntt_bf4_core #(
  parameter int WIDTH = 23,
  parameter int Q     = 8380417
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               mode,
  input  logic                     validi,
  input  logic [4*WIDTH-1:0]       datai,
  input  logic [6*WIDTH-1:0]       zetai,
  output logic [4*(WIDTH+1)-1:0]   data_o,
  output logic                     valido
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH:0] QX = (WIDTH+1)'(Q);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  function automatic logic [WIDTH-1:0] fold_in(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] s;
    s = {1'b0, x};
    if (s >= QX) s = s - QX;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    if (x >= y) s = {1'b0, x} - {1'b0, y};
    else        s = {1'b0, x} + QX - {1'b0, y};
    return s[WIDTH-1:0];
  endfunction

  // 2^23 == 2^13 - 1 (mod Q): three folds bring 46 bits under 2Q, then one subtract.
  function automatic logic [WIDTH-1:0] reduce(input logic [PW-1:0] p);
    logic [35:0] t1;
    logic [26:0] t2;
    logic [23:0] t3;
    t1 = ({13'b0, p[45:23]} << 13) - {13'b0, p[45:23]} + {13'b0, p[22:0]};
    t2 = ({14'b0, t1[35:23]} << 13) - {14'b0, t1[35:23]} + {4'b0, t1[22:0]};
    t3 = ({20'b0, t2[26:23]} << 13) - {20'b0, t2[26:23]} + {1'b0, t2[22:0]};
    if (t3 >= 24'(Q)) t3 = t3 - 24'(Q);
    return t3[22:0];
  endfunction

  logic             p1_v, p1_intt;
  logic [WIDTH-1:0] p1_a [4];
  logic [WIDTH-1:0] p1_z [6];

  logic             p2_v, p2_intt;
  logic [WIDTH-1:0] p2_pass [2];
  logic [WIDTH-1:0] p2_x [2];
  logic [WIDTH-1:0] p2_y [2];
  logic [WIDTH-1:0] p2_z [4];

  logic             p3_v, p3_intt;
  logic [WIDTH-1:0] p3_pass [2];
  logic [PW-1:0]    p3_prod [2];
  logic [WIDTH-1:0] p3_z [4];

  logic             p4_v, p4_intt;
  logic [WIDTH-1:0] p4_pass [2];
  logic [WIDTH-1:0] p4_r [2];
  logic [WIDTH-1:0] p4_z [4];

  logic             p5_v;
  logic [WIDTH-1:0] p5_x [4];
  logic [WIDTH-1:0] p5_y [4];

  logic             p6_v, p6_intt, p5_intt;
  logic [PW-1:0]    p6_prod [4];

  logic [WIDTH-1:0] s2_pass [2];
  logic [WIDTH-1:0] s2_x [2];
  logic [WIDTH-1:0] s5_b [4];
  logic [WIDTH-1:0] s5_x [4];
  logic [WIDTH-1:0] s5_y [4];
  logic [WIDTH-1:0] s7_r [4];
  logic [WIDTH-1:0] s7_c [4];

  // Layer-1 operand steering: GS adds/subtracts before the multiply, CT multiplies first.
  always_comb begin
    s2_pass[0] = p1_a[0];
    s2_pass[1] = p1_a[1];
    s2_x[0]    = p1_a[2];
    s2_x[1]    = p1_a[3];
    if (p1_intt) begin
      s2_pass[0] = add_mod(p1_a[0], p1_a[1]);
      s2_pass[1] = add_mod(p1_a[2], p1_a[3]);
      s2_x[0]    = sub_mod(p1_a[0], p1_a[1]);
      s2_x[1]    = sub_mod(p1_a[2], p1_a[3]);
    end
  end

  // Layer-2 steering; CT passes b0/b2 through the spare multipliers as x*1.
  always_comb begin
    s5_b[0] = p4_pass[0];
    s5_b[1] = p4_r[0];
    s5_b[2] = p4_pass[1];
    s5_b[3] = p4_r[1];
    s5_x[0] = add_mod(s5_b[0], s5_b[2]);
    s5_x[1] = add_mod(s5_b[1], s5_b[3]);
    s5_x[2] = sub_mod(s5_b[0], s5_b[2]);
    s5_x[3] = sub_mod(s5_b[1], s5_b[3]);
    s5_y[0] = p4_z[2];
    s5_y[1] = p4_z[3];
    s5_y[2] = p4_z[0];
    s5_y[3] = p4_z[1];
    if (!p4_intt) begin
      s5_b[0] = add_mod(p4_pass[0], p4_r[0]);
      s5_b[2] = sub_mod(p4_pass[0], p4_r[0]);
      s5_b[1] = add_mod(p4_pass[1], p4_r[1]);
      s5_b[3] = sub_mod(p4_pass[1], p4_r[1]);
      s5_x[0] = s5_b[1];
      s5_x[1] = s5_b[3];
      s5_x[2] = s5_b[0];
      s5_x[3] = s5_b[2];
      s5_y[0] = p4_z[0];
      s5_y[1] = p4_z[1];
      s5_y[2] = ONE;
      s5_y[3] = ONE;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) s7_r[i] = reduce(p6_prod[i]);
    s7_c[0] = s7_r[0];
    s7_c[1] = s7_r[1];
    s7_c[2] = s7_r[2];
    s7_c[3] = s7_r[3];
    if (!p6_intt) begin
      s7_c[0] = add_mod(s7_r[2], s7_r[0]);
      s7_c[1] = sub_mod(s7_r[2], s7_r[0]);
      s7_c[2] = add_mod(s7_r[3], s7_r[1]);
      s7_c[3] = sub_mod(s7_r[3], s7_r[1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p3_v <= 1'b0; p4_v <= 1'b0;
      p5_v <= 1'b0; p6_v <= 1'b0; valido <= 1'b0;
      p1_intt <= 1'b0; p2_intt <= 1'b0; p3_intt <= 1'b0; p4_intt <= 1'b0;
      p5_intt <= 1'b0; p6_intt <= 1'b0;
      data_o <= '0;
      for (int i = 0; i < 6; i++) p1_z[i] <= '0;
      for (int i = 0; i < 4; i++) begin
        p1_a[i] <= '0; p2_z[i] <= '0; p3_z[i] <= '0; p4_z[i] <= '0;
        p5_x[i] <= '0; p5_y[i] <= '0; p6_prod[i] <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        p2_pass[i] <= '0; p2_x[i] <= '0; p2_y[i] <= '0;
        p3_pass[i] <= '0; p3_prod[i] <= '0;
        p4_pass[i] <= '0; p4_r[i] <= '0;
      end
    end else begin
      p1_v <= validi;
      if (validi) begin
        p1_intt <= (mode == 3'd1);
        for (int i = 0; i < 4; i++) p1_a[i] <= fold_in(datai[WIDTH*i +: WIDTH]);
        for (int i = 0; i < 6; i++) p1_z[i] <= zetai[WIDTH*(5-i) +: WIDTH];
      end

      p2_v <= p1_v; p2_intt <= p1_intt;
      for (int i = 0; i < 2; i++) begin
        p2_pass[i] <= s2_pass[i];
        p2_x[i]    <= s2_x[i];
        p2_y[i]    <= p1_z[i];
      end
      for (int i = 0; i < 4; i++) p2_z[i] <= p1_z[i+2];

      p3_v <= p2_v; p3_intt <= p2_intt;
      for (int i = 0; i < 2; i++) begin
        p3_pass[i] <= p2_pass[i];
        p3_prod[i] <= {{WIDTH{1'b0}}, p2_x[i]} * {{WIDTH{1'b0}}, p2_y[i]};
      end
      for (int i = 0; i < 4; i++) p3_z[i] <= p2_z[i];

      p4_v <= p3_v; p4_intt <= p3_intt;
      for (int i = 0; i < 2; i++) begin
        p4_pass[i] <= p3_pass[i];
        p4_r[i]    <= reduce(p3_prod[i]);
      end
      for (int i = 0; i < 4; i++) p4_z[i] <= p3_z[i];

      p5_v <= p4_v; p5_intt <= p4_intt;
      for (int i = 0; i < 4; i++) begin
        p5_x[i] <= s5_x[i];
        p5_y[i] <= s5_y[i];
      end

      p6_v <= p5_v; p6_intt <= p5_intt;
      for (int i = 0; i < 4; i++)
        p6_prod[i] <= {{WIDTH{1'b0}}, p5_x[i]} * {{WIDTH{1'b0}}, p5_y[i]};

      valido <= p6_v;
      if (p6_v) begin
        for (int i = 0; i < 4; i++) data_o[(WIDTH+1)*i +: WIDTH+1] <= {1'b0, s7_c[i]};
      end
    end
  end

endmodule

// File: tb/tb_ntt_bf4_core.sv
// tb/tb_ntt_bf4_core.sv - self-checking bench for ntt_bf4_core against a plain mod-Q model
module tb_ntt_bf4_core;

  localparam int W = 23;
  localparam int Q = 8380417;

  logic          clk;
  logic          rst_n;
  logic [2:0]    mode;
  logic          validi;
  logic [91:0]   datai;
  logic [137:0]  zetai;
  logic [95:0]   data_o;
  logic          valido;

  ntt_bf4_core dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .validi(validi),
    .datai(datai), .zetai(zetai), .data_o(data_o), .valido(valido)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          due;
    logic [95:0] c;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          vectors = 0;
  int          checks = 0;
  int          miscompares = 0;
  logic [95:0] last_c = '0;
  int          edge_vals[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic longint am(input longint x, input longint y); return (x + y) % Q; endfunction
  function automatic longint sm(input longint x, input longint y); return (x - y + Q) % Q; endfunction
  function automatic longint mm(input longint x, input longint y); return (x * y) % Q; endfunction

  function automatic logic [95:0] model(input logic [2:0] m, input logic [91:0] d,
                                        input logic [137:0] zz, output logic [91:0] bo);
    longint a[4], z[6], b[4], c[4];
    logic [95:0] r;
    for (int i = 0; i < 4; i++) a[i] = longint'({41'b0, d[W*i +: W]}) % Q;
    for (int i = 0; i < 6; i++) z[i] = longint'({41'b0, zz[W*(5-i) +: W]}) % Q;
    if (m == 3'd1) begin
      b[0] = am(a[0], a[1]);
      b[1] = mm(sm(a[0], a[1]), z[0]);
      b[2] = am(a[2], a[3]);
      b[3] = mm(sm(a[2], a[3]), z[1]);
      c[0] = mm(am(b[0], b[2]), z[4]);
      c[1] = mm(am(b[1], b[3]), z[5]);
      c[2] = mm(sm(b[0], b[2]), z[2]);
      c[3] = mm(sm(b[1], b[3]), z[3]);
    end else begin
      b[0] = am(a[0], mm(z[0], a[2]));
      b[2] = sm(a[0], mm(z[0], a[2]));
      b[1] = am(a[1], mm(z[1], a[3]));
      b[3] = sm(a[1], mm(z[1], a[3]));
      c[0] = am(b[0], mm(z[2], b[1]));
      c[1] = sm(b[0], mm(z[2], b[1]));
      c[2] = am(b[2], mm(z[3], b[3]));
      c[3] = sm(b[2], mm(z[3], b[3]));
    end
    for (int i = 0; i < 4; i++) begin
      r[24*i +: 24] = 24'(c[i]);
      bo[W*i +: W]  = W'(b[i]);
    end
    return r;
  endfunction

  function automatic logic [91:0] pack_a(input int a0, input int a1, input int a2, input int a3);
    logic [91:0] r;
    r = {W'(a3), W'(a2), W'(a1), W'(a0)};
    return r;
  endfunction

  function automatic logic [137:0] pack_z_all(input int z);
    logic [137:0] r;
    for (int i = 0; i < 6; i++) r[W*i +: W] = W'(z);
    return r;
  endfunction

  function automatic logic [95:0] pack_c(input int c0, input int c1, input int c2, input int c3);
    logic [95:0] r;
    r = {24'(c3), 24'(c2), 24'(c1), 24'(c0)};
    return r;
  endfunction

  function automatic logic [22:0] pick();
    if ($urandom_range(0, 9) < 4) return W'(edge_vals[$urandom_range(0, 4)]);
    return W'($urandom());
  endfunction

  task automatic drive(input logic [2:0] m, input logic [91:0] d, input logic [137:0] z);
    exp_t e;
    logic [91:0] bo;
    @(posedge clk);
    #1;
    mode = m; datai = d; zetai = z; validi = 1'b1;
    e.due = cyc + 7;
    e.c = model(m, d, z, bo);
    exp_q.push_back(e);
    vectors++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      validi = 1'b0;
      mode   = 3'($urandom());
      datai  = 92'({$urandom(), $urandom(), $urandom()});
      zetai  = 138'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_valido", {95'b0, valido}, 96'b0);
      check("reset_data", data_o, 96'b0);
    end else begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        miscompares++;
        $display("FAIL missing_beat: got no valido at cycle %0d required one", exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        check("valido_high", {95'b0, valido}, {95'b0, 1'b1});
        check("data_o", data_o, exp_q[0].c);
        last_c = exp_q[0].c;
        void'(exp_q.pop_front());
      end else begin
        check("valido_low", {95'b0, valido}, 96'b0);
        check("data_hold", data_o, last_c);
      end
    end
  end

  initial begin
    logic [95:0]  m;
    logic [91:0]  bo;
    logic [91:0]  d;
    logic [137:0] z;

    edge_vals[0] = 0; edge_vals[1] = 1; edge_vals[2] = Q - 1;
    edge_vals[3] = Q; edge_vals[4] = 8388607;
    rst_n = 1'b0; validi = 1'b0; mode = 3'd0; datai = '0; zetai = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    m = model(3'd0, pack_a(1, 2, 3, 4), pack_z_all(1), bo);
    check("model_ntt_1234", m, pack_c(10, Q - 2, Q - 4, 0));
    m = model(3'd1, pack_a(1, 2, 3, 4), pack_z_all(1), bo);
    check("model_intt_1234", m, pack_c(10, Q - 2, Q - 4, 0));
    check("model_intt_b", {4'b0, bo}, {4'b0, pack_a(3, Q - 1, 7, Q - 1)});
    m = model(3'd0, pack_a(Q - 1, Q - 1, Q - 1, Q - 1), pack_z_all(Q - 1), bo);
    check("model_ntt_qm1", m, pack_c(0, 0, 0, Q - 4));
    m = model(3'd0, pack_a(8388607, 8388607, 8388607, 8388607), pack_z_all(1), bo);
    check("model_ntt_over_q", m, pack_c(32760, 0, 0, 0));

    drive(3'd0, pack_a(1, 2, 3, 4), pack_z_all(1));
    idle(9);
    drive(3'd1, pack_a(1, 2, 3, 4), pack_z_all(1));
    idle(9);
    drive(3'd0, pack_a(Q - 1, Q - 1, Q - 1, Q - 1), pack_z_all(Q - 1));
    drive(3'd0, pack_a(8388607, 8388607, 8388607, 8388607), pack_z_all(1));
    drive(3'd1, pack_a(8388607, 0, Q, 1), pack_z_all(8388607));
    drive(3'd5, pack_a(8388607, 1, Q - 1, Q), pack_z_all(Q));
    idle(9);

    for (int i = 0; i < 32; i++) begin
      d = 92'({$urandom(), $urandom(), $urandom()});
      z = 138'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      drive(3'(i % 2), d, z);
    end
    idle(10);

    for (int i = 0; i < 5; i++) drive(3'(i % 2), pack_a(i + 5, 7, 9, 11), pack_z_all(3));
    @(posedge clk);
    #1 validi = 1'b0;
    #1 rst_n = 1'b0;
    exp_q.delete();
    last_c = '0;
    #1;
    check("async_reset_valido", {95'b0, valido}, 96'b0);
    check("async_reset_data", data_o, 96'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(12);

    for (int i = 0; i < 10000; i++) begin
      d = {pick(), pick(), pick(), pick()};
      z = {pick(), pick(), pick(), pick(), pick(), pick()};
      drive(3'($urandom_range(0, 7)), d, z);
      if ($urandom_range(0, 99) == 0) idle($urandom_range(1, 3));
    end
    idle(12);

    check("queue_drained", 96'(exp_q.size()), 96'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
